tiger_leap_config_master: RTL and testbench

//  Avalon-MM master that drives the LEAP profiler slave port (leapSlave) from on-chip logic, removing the need for a JTAG master.
//  On start: holds Tiger in soft reset, programs the hash and profiler options, then releases the reset.
//  It then polls execution status and streams every counter value out on a result port.

---
 rtl/tiger_leap_config_master.sv | 221 ++++++++++++++++++++++
 tb/tb_tiger_leap_config_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiger_leap_config_master.sv
// Avalon-MM master that programs the LEAP profiler through leapSlave, then polls
// execution status and streams every counter value out on the result port.
module tiger_leap_config_master #(
  parameter int unsigned                 N2        = 8,
  parameter int unsigned                 TAB_WORDS = 4,
  parameter int unsigned                 NUM_CNT   = 16,
  parameter int unsigned                 POLL_GAP  = 16,
  parameter logic [31:0]                 V1        = 32'h447499e7,
  parameter logic [31:0]                 A1A2B1B2  = 32'h051c080f,
  parameter logic [32*TAB_WORDS-1:0]     TAB       = 128'h0001000007090b0c0004050e00080d0d,
  parameter logic [31:0]                 CNT_INC   = 32'h1,
  parameter logic [31:0]                 DO_HIER   = 32'h0,
  parameter logic [31:0]                 INIT_PC   = 32'h0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  output logic [N2-1:0] avm_address,
  output logic          avm_read,
  output logic          avm_write,
  output logic [31:0]   avm_writedata,
  input  logic [31:0]   avm_readdata,
  input  logic          avm_waitrequest,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  output logic [7:0]    res_index,
  output logic [31:0]   res_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SRST_ON,
    S_WR_V1,
    S_WR_AB,
    S_WR_TAB,
    S_WR_INC,
    S_WR_HIER,
    S_WR_PC,
    S_SRST_OFF,
    S_POLL_WAIT,
    S_POLL,
    S_READ_CNT,
    S_FIN
  } state_e;

  localparam logic [31:0] STAT_NOT_STARTED = 32'hFFFF_FFFE;
  localparam logic [31:0] STAT_RUNNING     = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  i_q, i_d;
  logic [15:0] gap_q, gap_d;
  logic        res_valid_q, res_valid_d;
  logic [7:0]  res_index_q, res_index_d;
  logic [31:0] res_data_q, res_data_d;
  logic        done_q, done_d;
  logic        xfer_done;

  function automatic logic [31:0] tab_word(input logic [7:0] k);
    logic [31:0] word;
    word = '0;
    for (int unsigned w = 0; w < TAB_WORDS; w++) begin
      if (k == w[7:0]) word = TAB[32*w +: 32];
    end
    return word;
  endfunction

  // Bus outputs decode straight from the state, so they hold while stalled and
  // fall to zero the cycle after an abort or immediately on reset.
  always_comb begin
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    unique case (state_q)
      S_SRST_ON: begin
        avm_write = 1'b1; avm_address = N2'(8'hC0); avm_writedata = 32'h1;
      end
      S_WR_V1: begin
        avm_write = 1'b1; avm_address = N2'(8'h00); avm_writedata = V1;
      end
      S_WR_AB: begin
        avm_write = 1'b1; avm_address = N2'(8'h01); avm_writedata = A1A2B1B2;
      end
      S_WR_TAB: begin
        avm_write = 1'b1; avm_address = N2'(8'h40 + k_q); avm_writedata = tab_word(k_q);
      end
      S_WR_INC: begin
        avm_write = 1'b1; avm_address = N2'(8'h80); avm_writedata = CNT_INC;
      end
      S_WR_HIER: begin
        avm_write = 1'b1; avm_address = N2'(8'h81); avm_writedata = DO_HIER;
      end
      S_WR_PC: begin
        avm_write = 1'b1; avm_address = N2'(8'h82); avm_writedata = INIT_PC;
      end
      S_SRST_OFF: begin
        avm_write = 1'b1; avm_address = N2'(8'hC0); avm_writedata = 32'h0;
      end
      S_POLL: begin
        avm_read = 1'b1; avm_address = N2'(8'h00);
      end
      S_READ_CNT: begin
        avm_read = 1'b1; avm_address = N2'(i_q);
      end
      default: ;
    endcase
  end

  assign xfer_done = (avm_read | avm_write) & ~avm_waitrequest;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    gap_d       = gap_q;
    res_valid_d = 1'b0;
    res_index_d = res_index_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      i_d     = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE:     if (start) state_d = S_SRST_ON;
        S_SRST_ON:  if (xfer_done) state_d = S_WR_V1;
        S_WR_V1:    if (xfer_done) state_d = S_WR_AB;
        S_WR_AB:    if (xfer_done) state_d = S_WR_TAB;
        S_WR_TAB: begin
          if (xfer_done) begin
            if (k_q == 8'(TAB_WORDS - 1)) begin
              k_d     = '0;
              state_d = S_WR_INC;
            end else begin
              k_d = k_q + 8'd1;
            end
          end
        end
        S_WR_INC:   if (xfer_done) state_d = S_WR_HIER;
        S_WR_HIER:  if (xfer_done) state_d = S_WR_PC;
        S_WR_PC:    if (xfer_done) state_d = S_SRST_OFF;
        S_SRST_OFF: begin
          if (xfer_done) begin
            gap_d   = '0;
            state_d = S_POLL_WAIT;
          end
        end
        S_POLL_WAIT: begin
          if (gap_q == 16'(POLL_GAP - 1)) begin
            gap_d   = '0;
            state_d = S_POLL;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
        S_POLL: begin
          if (xfer_done) begin
            if (avm_readdata == STAT_NOT_STARTED || avm_readdata == STAT_RUNNING) begin
              state_d = S_POLL_WAIT;
            end else begin
              i_d     = '0;
              state_d = S_READ_CNT;
            end
          end
        end
        S_READ_CNT: begin
          if (xfer_done) begin
            res_valid_d = 1'b1;
            res_index_d = i_q;
            res_data_d  = avm_readdata;
            if (i_q == 8'(NUM_CNT - 1)) begin
              i_d     = '0;
              state_d = S_FIN;
            end else begin
              i_d = i_q + 8'd1;
            end
          end
        end
        S_FIN: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      gap_q       <= '0;
      res_valid_q <= 1'b0;
      res_index_q <= '0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      gap_q       <= gap_d;
      res_valid_q <= res_valid_d;
      res_index_q <= res_index_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign res_valid = res_valid_q;
  assign res_index = res_index_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_tiger_leap_config_master.sv
// Directed bench for tiger_leap_config_master: a behavioural leapSlave with
// scripted status words, stall injection, and logs of every completed transfer.
module tb_tiger_leap_config_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [7:0]  avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic        busy, done, res_valid;
  logic [7:0]  res_index;
  logic [31:0] res_data;

  always #5 clk = ~clk;

  tiger_leap_config_master #(
    .N2(8), .TAB_WORDS(4), .NUM_CNT(16), .POLL_GAP(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done),
    .res_valid(res_valid), .res_index(res_index), .res_data(res_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0]  exp_wa [11] = '{8'hC0, 8'h00, 8'h01, 8'h40, 8'h41, 8'h42, 8'h43,
                                8'h80, 8'h81, 8'h82, 8'hC0};
  logic [31:0] exp_wd [11] = '{32'h1, 32'h447499e7, 32'h051c080f, 32'h00080d0d,
                                32'h0004050e, 32'h07090b0c, 32'h00010000,
                                32'h1, 32'h0, 32'h0, 32'h0};

  // Slave model: address 0 returns the scripted status sequence, others 100+addr.
  logic [31:0] stat_tab [4];
  int unsigned stat_cnt = 0, stat_base = 0;
  int unsigned stall_cnt = 0, stall_lim = 0;
  logic [7:0]  stall_addr = 8'hFF;

  always_comb begin
    int unsigned si;
    si = stat_cnt - stat_base;
    if (si > 3) si = 3;
    avm_readdata = (avm_address == 8'h00) ? stat_tab[si] : 32'd100 + 32'(avm_address);
  end

  always_comb avm_waitrequest = avm_write && (avm_address == stall_addr) && (stall_cnt < stall_lim);

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read && !avm_waitrequest && avm_address == 8'h00) stat_cnt <= stat_cnt + 1;
    if (avm_waitrequest) stall_cnt <= stall_cnt + 1;
  end

  int          wr_cyc[$], rd_cyc[$], res_cyc[$], done_cyc[$];
  logic [7:0]  wr_a[$], rd_a[$], res_i[$];
  logic [31:0] wr_d[$], res_d[$];
  logic        done_busy[$];
  int          ovl_err = 0, hold_err = 0;
  logic        prev_wait = 1'b0, prev_abort = 1'b0, prev_w = 1'b0, prev_r = 1'b0;
  logic [7:0]  prev_a = '0;
  logic [31:0] prev_d = '0;

  always @(negedge clk) begin
    if (avm_write && !avm_waitrequest) begin
      wr_a.push_back(avm_address); wr_d.push_back(avm_writedata); wr_cyc.push_back(cyc);
    end
    if (avm_read && !avm_waitrequest) begin
      rd_a.push_back(avm_address); rd_cyc.push_back(cyc);
    end
    if (res_valid) begin
      res_i.push_back(res_index); res_d.push_back(res_data); res_cyc.push_back(cyc);
    end
    if (done) begin
      done_cyc.push_back(cyc); done_busy.push_back(busy);
    end
    if (avm_read && avm_write) ovl_err <= ovl_err + 1;
    if (prev_wait && !prev_abort &&
        (avm_address != prev_a || avm_writedata != prev_d || avm_write != prev_w || avm_read != prev_r))
      hold_err <= hold_err + 1;
    prev_wait  <= avm_waitrequest;
    prev_abort <= abort;
    prev_a     <= avm_address;
    prev_d     <= avm_writedata;
    prev_w     <= avm_write;
    prev_r     <= avm_read;
  end

  task automatic set_status(input logic [31:0] s0, s1, s2, s3);
    stat_tab[0] = s0; stat_tab[1] = s1; stat_tab[2] = s2; stat_tab[3] = s3;
    stat_base = stat_cnt;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int db, n;
    db = done_cyc.size();
    n  = 0;
    pulse_start();
    while (done_cyc.size() == db && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cyc.size() - db), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_bus(input string tag, input logic [7:0] a, input logic rd);
    int n;
    n = 0;
    while (!((rd ? avm_read : avm_write) && avm_address == a) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_reached"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int b);
    check({tag, "_wr_count"}, 32'(wr_a.size() - b), 32'd11);
    for (int j = 0; j < 11; j++) begin
      if (b + j < wr_a.size()) begin
        check($sformatf("%s_wr%0d_addr", tag, j), 32'(wr_a[b+j]), 32'(exp_wa[j]));
        check($sformatf("%s_wr%0d_data", tag, j), wr_d[b+j], exp_wd[j]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctl"}, {27'b0, avm_read, avm_write, busy, done, res_valid}, 32'h0);
    check({tag, "_addr"}, 32'(avm_address), 32'h0);
    check({tag, "_wdata"}, avm_writedata, 32'h0);
    check({tag, "_res_index"}, 32'(res_index), 32'h0);
    check({tag, "_res_data"}, res_data, 32'h0);
  endtask

  initial begin
    int wb, rb, sb, db, resb;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_status(32'h5, 32'h5, 32'h5, 32'h5);
    #2;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // T1 + T3: back-to-back writes, polling through both sentinels, counter 0 re-read.
    set_status(32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7);
    wb = wr_a.size(); rb = rd_a.size(); resb = res_d.size();
    run_to_done("t1");
    check_writes("t1", wb);
    for (int j = 1; j < 11; j++)
      check($sformatf("t1_wr%0d_gap", j), 32'(wr_cyc[wb+j] - wr_cyc[wb+j-1]), 32'd1);
    check("t3_rd_count", 32'(rd_a.size() - rb), 32'd20);
    check("t3_first_poll_gap", 32'(rd_cyc[rb] - wr_cyc[wb+10]), 32'd17);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("t3_poll%0d_addr", j + 1), 32'(rd_a[rb+j+1]), 32'h0);
      check($sformatf("t3_poll%0d_gap", j + 1), 32'(rd_cyc[rb+j+1] - rd_cyc[rb+j]), 32'd17);
    end
    check("t3_first_cnt_read_cycle", 32'(rd_cyc[rb+4] - rd_cyc[rb+3]), 32'd1);
    check("t3_res0_data", res_d[resb], 32'h7);
    check("t3_res1_data", res_d[resb+1], 32'd101);

    // T4: counters 100+i, with a stray start mid-run that must be ignored.
    set_status(32'd100, 32'd100, 32'd100, 32'd100);
    wb = wr_a.size(); rb = rd_a.size(); resb = res_d.size(); db = done_cyc.size();
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    begin
      int n;
      n = 0;
      while (done_cyc.size() == db && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("t4_done_seen", 32'(done_cyc.size() - db), 32'd1);
      repeat (2) @(posedge clk);
      #1;
    end
    check_writes("t4", wb);
    check("t4_res_count", 32'(res_d.size() - resb), 32'd16);
    for (int j = 0; j < 16; j++) begin
      if (resb + j < res_d.size()) begin
        check($sformatf("t4_res%0d_index", j), 32'(res_i[resb+j]), 32'(j));
        check($sformatf("t4_res%0d_data", j), res_d[resb+j], 32'd100 + 32'(j));
      end
    end
    check("t4_res15_after_read", 32'(res_cyc[resb+15] - rd_cyc[rd_cyc.size()-1]), 32'd1);
    check("t4_done_after_res15", 32'(done_cyc[db] - res_cyc[resb+15]), 32'd1);
    check("t4_busy_with_done", 32'(done_busy[db]), 32'd0);

    // T2: three stall cycles on the 0x01 write.
    set_status(32'h5, 32'h5, 32'h5, 32'h5);
    stall_addr = 8'h01;
    sb = stall_cnt;
    stall_lim = stall_cnt + 3;
    wb = wr_a.size();
    run_to_done("t2");
    check_writes("t2", wb);
    check("t2_stall_cycles", 32'(stall_cnt - sb), 32'd3);
    check("t2_ab_delay", 32'(wr_cyc[wb+2] - wr_cyc[wb+1]), 32'd4);
    check("t2_tab0_follows", 32'(wr_cyc[wb+3] - wr_cyc[wb+2]), 32'd1);
    stall_addr = 8'hFF;

    // start and abort together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_write", 32'(avm_write), 32'd0);

    // T5: abort while the 0x41 write is stalled.
    stall_addr = 8'h41;
    stall_lim = stall_cnt + 1000;
    wb = wr_a.size(); db = done_cyc.size(); resb = res_d.size();
    pulse_start();
    wait_bus("t5", 8'h41, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_stalled", 32'(avm_waitrequest), 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_write_dropped", 32'(avm_write), 32'd0);
    check("t5_busy_dropped", 32'(busy), 32'd0);
    stall_addr = 8'hFF;
    repeat (40) @(posedge clk);
    #1;
    check("t5_wr_count", 32'(wr_a.size() - wb), 32'd4);
    check("t5_last_wr_addr", 32'(wr_a[wr_a.size()-1]), 32'h40);
    check("t5_no_done", 32'(done_cyc.size() - db), 32'd0);
    check("t5_no_res", 32'(res_d.size() - resb), 32'd0);
    wb = wr_a.size();
    run_to_done("t5_rerun");
    check_writes("t5_rerun", wb);

    // T6: asynchronous reset while reading counters.
    set_status(32'd100, 32'd100, 32'd100, 32'd100);
    pulse_start();
    wait_bus("t6", 8'h03, 1'b1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("t6_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    wb = wr_a.size();
    run_to_done("t6_rerun");
    check_writes("t6_rerun", wb);

    check("no_rw_overlap", 32'(ovl_err), 32'd0);
    check("hold_while_stalled", 32'(hold_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
